rgmii_tx_speed_adapt: RTL

- Parametrised transmit-side GMII-to-RGMII adapter. It produces registered DDR feed values (two phases per clk) for the TXC, TD and TX_CTL output DDR cells.
- Runs on the single GTX clock. Divide ratios for 10/100 are parameters, not fixed.
- Adds an optional byte mode: at 10/100 the MAC presents whole bytes and the block serialises nibbles, low nibble first.
- Adds glitch-free speed changes: a new speed takes effect only on an idle clock-period boundary.

---
 rtl/rgmii_pkg.sv | 18 +
 rtl/rgmii_tx_speed_adapt_if.sv | 10 +
 rtl/rgmii_txc_gen.sv | 73 +++++++
 rtl/rgmii_tx_speed_adapt.sv | 81 ++++++++
 4 files changed

// File: rtl/rgmii_pkg.sv
// rtl/rgmii_pkg.sv - speed encodings and helpers shared by the RGMII transmit adapter
package rgmii_pkg;

   typedef enum logic [1:0] {
      SPEED_10M  = 2'b00,
      SPEED_100M = 2'b01,
      SPEED_1G   = 2'b10
   } speed_t;

   // The reserved code 2'b11 is treated as gigabit.
   function automatic speed_t speed_norm(input logic [1:0] s);
      if (s == 2'b11)
         return SPEED_1G;
      else
         return speed_t'(s);
   endfunction

endpackage

// File: rtl/rgmii_tx_speed_adapt_if.sv
// rtl/rgmii_tx_speed_adapt_if.sv - GMII transmit bundle between MAC and adapter
interface rgmii_tx_speed_adapt_if;
   logic [7:0] gmii_txd;
   logic       gmii_tx_en;
   logic       gmii_tx_er;
   logic       gmii_tx_clk_en;

   modport master (output gmii_txd, gmii_tx_en, gmii_tx_er, input gmii_tx_clk_en);
   modport slave  (input gmii_txd, gmii_tx_en, gmii_tx_er, output gmii_tx_clk_en);
endinterface

// File: rtl/rgmii_txc_gen.sv
// rtl/rgmii_txc_gen.sv - TXC period counter, nibble phase and DDR clock pattern
module rgmii_txc_gen
   import rgmii_pkg::*;
#(
   parameter int DIV_100M  = 5,
   parameter int DIV_10M   = 50,
   parameter int BYTE_MODE = 0
) (
   input  logic   clk,
   input  logic   rst,
   input  speed_t active_speed,
   input  logic   commit,
   output logic   txc_d1,
   output logic   txc_d2,
   output logic   strobe,
   output logic   phase
);
   localparam int CNT_W = $clog2(DIV_10M);
   localparam logic [CNT_W-1:0] LAST_100 = CNT_W'(DIV_100M - 1);
   localparam logic [CNT_W-1:0] LAST_10  = CNT_W'(DIV_10M - 1);
   localparam logic [CNT_W-1:0] HALF_100 = CNT_W'(DIV_100M / 2);
   localparam logic [CNT_W-1:0] HALF_10  = CNT_W'(DIV_10M / 2);
   localparam bit ODD_100 = (DIV_100M % 2) == 1;
   localparam bit ODD_10  = (DIV_10M % 2) == 1;

   logic [CNT_W-1:0] c, last, half;
   logic             run, is_1g, is_10, odd, at_last;

   assign is_1g   = (active_speed == SPEED_1G);
   assign is_10   = (active_speed == SPEED_10M);
   assign last    = is_10 ? LAST_10 : LAST_100;
   assign half    = is_10 ? HALF_10 : HALF_100;
   assign odd     = is_10 ? ODD_10 : ODD_100;
   assign at_last = (c == last);

   // The data-advance strobe doubles as the speed-change boundary.
   assign strobe = run && (is_1g || (at_last && (BYTE_MODE == 0 || phase)));

   always_comb begin
      txc_d1 = 1'b0;
      txc_d2 = 1'b0;
      if (run) begin
         if (is_1g) begin
            txc_d1 = 1'b1;
         end else if (c == half && odd) begin
            txc_d2 = 1'b1;
         end else if (c > half || (c == half && !odd)) begin
            txc_d1 = 1'b1;
            txc_d2 = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c     <= '0;
         phase <= 1'b0;
         run   <= 1'b0;
      end else begin
         run <= 1'b1;
         if (!run || is_1g || commit) begin
            c     <= '0;
            phase <= 1'b0;
         end else if (at_last) begin
            c     <= '0;
            phase <= ~phase;
         end else begin
            c <= c + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/rgmii_tx_speed_adapt.sv
// rtl/rgmii_tx_speed_adapt.sv - GMII to RGMII transmit adapter with glitch-free speed changes
module rgmii_tx_speed_adapt
   import rgmii_pkg::*;
#(
   parameter int DIV_100M  = 5,
   parameter int DIV_10M   = 50,
   parameter int BYTE_MODE = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            speed,
   rgmii_tx_speed_adapt_if.slave gmii,
   output logic [1:0]            active_speed,
   output logic                  speed_pending,
   output logic                  txc_d1,
   output logic                  txc_d2,
   output logic [3:0]            td_d1,
   output logic [3:0]            td_d2,
   output logic                  tx_ctl_d1,
   output logic                  tx_ctl_d2
);
   speed_t     act, req;
   logic [7:0] cap_d;
   logic       cap_en, cap_er, strobe, phase, commit, is_1g, en_x_er;
   logic [3:0] nib;

   assign req           = speed_norm(speed);
   assign speed_pending = (req != act);
   assign active_speed  = act;
   assign is_1g         = (act == SPEED_1G);
   assign en_x_er       = cap_en ^ cap_er;
   // Never switch in the middle of a frame.
   assign commit        = speed_pending && !cap_en && strobe;
   assign gmii.gmii_tx_clk_en = strobe;

   rgmii_txc_gen #(
      .DIV_100M  (DIV_100M),
      .DIV_10M   (DIV_10M),
      .BYTE_MODE (BYTE_MODE)
   ) u_txc_gen (
      .clk          (clk),
      .rst          (rst),
      .active_speed (act),
      .commit       (commit),
      .txc_d1       (txc_d1),
      .txc_d2       (txc_d2),
      .strobe       (strobe),
      .phase        (phase)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act    <= SPEED_1G;
         cap_d  <= '0;
         cap_en <= 1'b0;
         cap_er <= 1'b0;
      end else if (strobe) begin
         cap_d  <= gmii.gmii_txd;
         cap_en <= gmii.gmii_tx_en;
         cap_er <= gmii.gmii_tx_er;
         if (commit)
            act <= req;
      end
   end

   always_comb begin
      nib = (BYTE_MODE != 0 && phase) ? cap_d[7:4] : cap_d[3:0];
      if (is_1g) begin
         td_d1     = cap_d[3:0];
         td_d2     = cap_d[7:4];
         tx_ctl_d1 = cap_en;
         tx_ctl_d2 = en_x_er;
      end else begin
         td_d1     = nib;
         td_d2     = nib;
         tx_ctl_d1 = txc_d1 ? en_x_er : cap_en;
         tx_ctl_d2 = txc_d2 ? en_x_er : cap_en;
      end
   end

endmodule
